ex_mem_merge: RTL
=================

// Module: ex_mem_merge
// PURPOSE
//  Result-merge buffer between the execute stage (single-cycle ALU plus multi-cycle
//  MUL/DIV unit) and the MEM stage. Accepts pipe_buff_t results from both sources,
//  arbitrates one push per cycle and queues them in an in-order FIFO. Presents the
//  head entry to MEM with valid/ready flow control.
//  Back-pressures the ALU through a stall and the MDU through an accept strobe.
// PARAMETERS
//  DEPTH        2  FIFO entries; power of two, 2..8
//  MDU_PRIORITY 1  1: MDU wins simultaneous pushes; 0: ALU wins
// PORTS
//  i_clk            in   1                  clock, rising edge
//  i_rst_n          in   1                  reset, asynchronous, active-low
//  i_alu_pkg        in   pipe_buff_t        ALU result {rd_data,rd_addr,wren,valid}
//  i_mdu_pkg        in   pipe_buff_t        MDU result, held stable until o_mdu_ack
//  i_flush          in   1                  pipeline flush (branch mispredict)
//  i_mem_ready      in   1                  MEM stage accepts head this cycle
//  o_ex_mem_pkg     out  pipe_buff_t        head entry to MEM stage
//  o_alu_stall      out  1                  ALU result not taken; upstream must hold
//  o_mdu_ack        out  1                  MDU result pushed this cycle
//  o_occupancy      out  $clog2(DEPTH)+1    entries currently held
// BEHAVIOUR
//  - Reset: rd/wr pointers = 0, count = 0.
//    o_ex_mem_pkg = '0 (valid = 0). o_alu_stall = 0, o_mdu_ack = 0, o_occupancy = 0.
//  - Storage: circular FIFO, DEPTH x {rd_data[31:0], rd_addr[4:0], wren}.
//    Pointers wrap modulo DEPTH.
//  - pop  = o_ex_mem_pkg.valid & i_mem_ready.
//  - space = (count < DEPTH) | pop. A full FIFO with a same-cycle pop accepts a push.
//  - Arbitration (combinational):
//    - At most one push per cycle.
//    - Candidates are the sources with .valid = 1.
//    - If both are valid, MDU_PRIORITY selects the winner.
//    - Push only if space.
//  - o_mdu_ack = MDU chosen & space & ~i_flush.
//  - o_alu_stall = i_alu_pkg.valid & ~(ALU chosen & space) & ~i_flush.
//  - On push: entry written at wr_ptr.
//    - wren stored as (wren & rd_addr != 0); x0 writes are neutralised here.
//    - rd_data is stored unchanged.
//  - Output:
//    - o_ex_mem_pkg.valid = (count != 0).
//    - Data fields = head entry when valid, else all zero (no stale data visible).
//  - Latency: input push to output valid = 1 cycle. Throughput: 1 entry/cycle.
//  - Simultaneous push+pop: count unchanged, both pointers advance.
//  - Full & ~pop: no push. A valid ALU input raises o_alu_stall; o_mdu_ack stays 0.
//  - Empty: pop impossible; i_mem_ready ignored.
//  - i_flush:
//    - Synchronous. Next edge: pointers = 0, count = 0.
//    - Same-cycle inputs are dropped. No push, ack = 0, stall = 0.
//    - A pop in the flush cycle is still presented but MEM must discard it.
//  - Reset asserted mid-operation: all state cleared immediately (asynchronous).
//  - Order: entries leave in push order. No reordering between ALU and MDU results.
// CONFIGURATION
//  EX_MEM_BYPASS_EN defined:
//    - When count == 0, no flush, and a push occurs, the winning input drives
//      o_ex_mem_pkg combinationally (zero latency).
//    - If i_mem_ready is also 1, the entry is not written.
//    - Otherwise it is written as normal.
//    - o_occupancy is unaffected by a bypassed entry.
//  EX_MEM_BYPASS_EN undefined:
//    - Registered-only path. Fixed 1-cycle latency, no input-to-output
//      combinational path (timing-safe default).
// TESTING
//  1. Reset: i_rst_n=0 mid-stream with 2 entries held -> o_ex_mem_pkg.valid=0,
//     o_occupancy=0 immediately, before the next clock edge.
//  2. Stream: ALU valid each cycle rd_data=1,2,3, i_mem_ready=1 -> MEM sees 1,2,3
//     one cycle later; o_alu_stall never asserted.
//  3. Collision, MDU_PRIORITY=1: ALU (rd=5,data=0xAA) and MDU (rd=6,data=0xBB) both
//     valid -> o_mdu_ack=1, o_alu_stall=1. Next cycle ALU pushed.
//     Output order: 0xBB then 0xAA.
//  4. Full: DEPTH=2, i_mem_ready=0, 3 ALU pushes -> third cycle o_alu_stall=1,
//     o_occupancy=2. Then i_mem_ready=1 -> push+pop same cycle, occupancy stays 2.
//  5. x0 write: ALU push rd_addr=0, wren=1, data=0x1234 -> output wren=0,
//     rd_data=0x1234.
//  6. Flush: 2 entries held, i_flush=1 with ALU valid -> next cycle valid=0,
//     occupancy=0; ALU entry absent. With EX_MEM_BYPASS_EN: empty FIFO,
//     ALU push data=0x7 -> o_ex_mem_pkg.valid=1, rd_data=0x7 same cycle.

Source files
------------

// File: rtl/ex_mem_merge.sv
// ----------------------------------------------------------------------------
// ex_mem_merge
//
// Result-merge buffer between the execute stage and the MEM stage. The
// single-cycle ALU and the multi-cycle MUL/DIV unit (MDU) both produce
// pipe_buff_t results. At most one of them is pushed per cycle into a small
// in-order circular FIFO. The head entry is presented to MEM.
//
// pipe_buff_t is carried as a flat 39-bit vector:
//   [38:7] rd_data   [6:2] rd_addr   [1] wren   [0] valid
//
// Parameters
//   DEPTH        FIFO entries, power of two in 2..8
//   MDU_PRIORITY 1: MDU wins simultaneous pushes, 0: ALU wins
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_alu_pkg      ALU result; the ALU holds it while o_alu_stall is high
//   i_mdu_pkg      MDU result; held stable until o_mdu_ack
//   i_flush        synchronous pipeline flush; drops same-cycle inputs
//   i_mem_ready    MEM accepts the head entry this cycle
//   o_ex_mem_pkg   head entry to MEM (all zero when not valid)
//   o_alu_stall    ALU result not taken this cycle
//   o_mdu_ack      MDU result pushed this cycle
//   o_occupancy    number of entries held
//
// Flow control: an entry transfers to MEM on any rising edge where
// o_ex_mem_pkg[0] (valid) and i_mem_ready are both high. valid never depends
// on i_mem_ready, and the presented entry stays put until it is taken
// (except on flush or reset).
//
// Optional build macro EX_MEM_BYPASS_EN: when the FIFO is empty and a push
// happens, the winning input is forwarded to o_ex_mem_pkg in the same cycle.
// If MEM also takes it that cycle, it is not written into the FIFO. Without
// the macro the output is purely registered (no input-to-output path).
// ----------------------------------------------------------------------------
module ex_mem_merge #(
    parameter int DEPTH        = 2,
    parameter bit MDU_PRIORITY = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [38:0]                i_alu_pkg,
    input  logic [38:0]                i_mdu_pkg,
    input  logic                       i_flush,
    input  logic                       i_mem_ready,
    output logic [38:0]                o_ex_mem_pkg,
    output logic                       o_alu_stall,
    output logic                       o_mdu_ack,
    output logic [$clog2(DEPTH):0]     o_occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   mem_data [DEPTH];
    logic [4:0]    mem_addr [DEPTH];
    logic          mem_wren [DEPTH];

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // ------------------------------------------------------------------
    // Source decode
    // ------------------------------------------------------------------
    logic          alu_valid;
    logic          mdu_valid;
    logic          alu_sel;
    logic          mdu_sel;

    assign alu_valid = i_alu_pkg[0];
    assign mdu_valid = i_mdu_pkg[0];

    // With MDU priority the ALU only wins when the MDU is idle; otherwise the
    // ALU wins whenever it is valid. The MDU takes whatever the ALU leaves.
    assign alu_sel = alu_valid & (!MDU_PRIORITY | ~mdu_valid);
    assign mdu_sel = mdu_valid & ~alu_sel;

    // ------------------------------------------------------------------
    // Pop / space / push
    // ------------------------------------------------------------------
    logic          fifo_valid;
    logic          fifo_pop;
    logic          space;
    logic          push;
    logic          bypass;
    logic          write_en;

    assign fifo_valid = (count_q != '0);
    // An empty FIFO has nothing to pop, so i_mem_ready is ignored there.
    assign fifo_pop   = fifo_valid & i_mem_ready;
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign space      = (count_q < CW'(DEPTH)) | fifo_pop;
    assign push       = (alu_sel | mdu_sel) & space & ~i_flush;

    assign o_mdu_ack   = mdu_sel & space & ~i_flush;
    assign o_alu_stall = alu_valid & ~(alu_sel & space) & ~i_flush;

    // Winning input, with writes to x0 neutralised before storage so MEM and
    // writeback never need to special-case register zero.
    logic [38:0]   win_pkg;
    logic [31:0]   win_data;
    logic [4:0]    win_addr;
    logic          win_wren;

    assign win_pkg  = mdu_sel ? i_mdu_pkg : i_alu_pkg;
    assign win_data = win_pkg[38:7];
    assign win_addr = win_pkg[6:2];
    assign win_wren = win_pkg[1] & (win_pkg[6:2] != 5'd0);

`ifdef EX_MEM_BYPASS_EN
    // Forward straight to MEM when nothing older is queued. If MEM takes it
    // this cycle it never occupies a FIFO slot.
    assign bypass   = ~fifo_valid & push;
    assign write_en = push & ~(bypass & i_mem_ready);
`else
    assign bypass   = 1'b0;
    assign write_en = push;
`endif

    // ------------------------------------------------------------------
    // Storage array (data path only, no reset needed: the output is gated
    // by fifo_valid so stale contents are never visible)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (write_en) begin
            mem_data[wr_ptr_q] <= win_data;
            mem_addr[wr_ptr_q] <= win_addr;
            mem_wren[wr_ptr_q] <= win_wren;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and count. Pointer width is log2(DEPTH), so natural
    // overflow gives the modulo-DEPTH wrap.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (write_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({write_en, fifo_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output to MEM
    // ------------------------------------------------------------------
    always_comb begin
        o_ex_mem_pkg = '0;
        if (fifo_valid) begin
            o_ex_mem_pkg = {mem_data[rd_ptr_q], mem_addr[rd_ptr_q],
                            mem_wren[rd_ptr_q], 1'b1};
        end else if (bypass) begin
            o_ex_mem_pkg = {win_data, win_addr, win_wren, 1'b1};
        end
    end

    assign o_occupancy = count_q;

endmodule
